// File: rtl/writeback_stage.sv
// Writeback pipeline stage: picks the write data source, extracts and extends load
// lanes, and flags misaligned or unsupported loads. Also counts retired instructions.
module writeback_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            writeback_data_sel,
  input  logic [2:0]            load_funct3,
  input  logic [1:0]            byte_offset,
  input  logic [XLEN-1:0]       alu_data_out,
  input  logic [XLEN-1:0]       PC_in,
  input  logic [XLEN-1:0]       dm_read_data,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  rd_write_in,
  output logic [XLEN-1:0]       writeback_data,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rd_write_en,
  output logic                  wb_valid,
  output logic                  misaligned_load,
  output logic [XLEN-1:0]       retire_count
);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;
  localparam logic [1:0] SEL_IMM = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [XLEN-1:0]       writeback_data_reg, writeback_data_next;
  logic [REG_ADDR_W-1:0] rd_addr_reg;
  logic                  rd_write_en_reg, rd_write_en_next;
  logic                  wb_valid_reg;
  logic                  misaligned_load_reg, misaligned_load_next;
  logic [XLEN-1:0]       retire_count_reg;

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic            load_unsupported;
  logic            load_misaligned;
  logic            is_load;

  // Lane selection: byte lane follows the full offset, half lane only offset bit 1.
  assign load_byte = dm_read_data[{byte_offset, 3'b000} +: 8];
  assign load_half = dm_read_data[{byte_offset[1], 4'b0000} +: 16];
  assign is_load   = (writeback_data_sel == SEL_MEM);

  always_comb begin
    load_data        = '0;
    load_unsupported = 1'b0;
    load_misaligned  = 1'b0;
    case (load_funct3)
      F3_LB:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LBU: load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LH: begin
        load_data       = {{(XLEN-16){load_half[15]}}, load_half};
        load_misaligned = byte_offset[0];
      end
      F3_LHU: begin
        load_data       = {{(XLEN-16){1'b0}}, load_half};
        load_misaligned = byte_offset[0];
      end
      F3_LW: begin
        load_data       = dm_read_data;
        load_misaligned = (byte_offset != 2'b00);
      end
      default: load_unsupported = 1'b1;
    endcase
  end

  always_comb begin
    writeback_data_next = alu_data_out;
    case (writeback_data_sel)
      SEL_ALU: writeback_data_next = alu_data_out;
      SEL_MEM: writeback_data_next = load_data;
      SEL_PC:  writeback_data_next = PC_in + XLEN'(4);
      SEL_IMM: writeback_data_next = imm_in;
      default: writeback_data_next = alu_data_out;
    endcase
  end

  // A faulting or unsupported load still retires, but must never reach the register file.
  always_comb begin
    misaligned_load_next = in_valid && is_load && load_misaligned;
    rd_write_en_next     = in_valid && rd_write_in && (rd_addr_in != '0)
                           && !(is_load && (load_misaligned || load_unsupported));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      writeback_data_reg  <= '0;
      rd_addr_reg         <= '0;
      rd_write_en_reg     <= 1'b0;
      wb_valid_reg        <= 1'b0;
      misaligned_load_reg <= 1'b0;
      retire_count_reg    <= '0;
    end else if (flush) begin
      rd_write_en_reg     <= 1'b0;
      wb_valid_reg        <= 1'b0;
      misaligned_load_reg <= 1'b0;
    end else if (!stall) begin
      writeback_data_reg  <= writeback_data_next;
      rd_addr_reg         <= rd_addr_in;
      rd_write_en_reg     <= rd_write_en_next;
      wb_valid_reg        <= in_valid;
      misaligned_load_reg <= misaligned_load_next;
      if (in_valid) begin
        retire_count_reg <= retire_count_reg + XLEN'(1);
      end
    end
  end

  assign writeback_data  = writeback_data_reg;
  assign rd_addr         = rd_addr_reg;
  assign rd_write_en     = rd_write_en_reg;
  assign wb_valid        = wb_valid_reg;
  assign misaligned_load = misaligned_load_reg;
  assign retire_count    = retire_count_reg;

endmodule
